// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage (mcause, mstatus, mepc, mtvec).
// One combinational read port, one registered software write port, and a
// hardware trap/mret port that updates several CSRs on the same edge.
//
// Request semantics: there is no valid/ready handshake. Every request
// (csrf_wen, trap_vld, mret_vld) is a single-cycle strobe that is always
// accepted on the rising edge where it is high. Priority is
// trap_vld > mret_vld > software write. A software write that loses to a
// higher-priority update is dropped, and wr_conflict pulses on that edge.
module csr_regfile #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] csrf_raddr,
  output logic [DATA_WIDTH-1:0] csrf_rdata,
  input  logic [ADDR_WIDTH-1:0] csrf_waddr,
  input  logic [DATA_WIDTH-1:0] csrf_wdata,
  input  logic                  csrf_wen,
  input  logic                  trap_vld,
  input  logic [63:0]           trap_pc,
  input  logic [63:0]           trap_cause,
  input  logic                  mret_vld,
  output logic [63:0]           mtvec_o,
  output logic [63:0]           mepc_o,
  output logic                  mie_o,
  output logic                  wr_conflict
);

  // Compact CSR indices
  localparam logic [1:0] IDX_MCAUSE  = 2'd0;
  localparam logic [1:0] IDX_MSTATUS = 2'd1;
  localparam logic [1:0] IDX_MEPC    = 2'd2;
  localparam logic [1:0] IDX_MTVEC   = 2'd3;

  // mstatus fixed fields: SXL = 2'b10, UXL = 2'b10, MPP = 2'b11
  localparam logic [63:0] MSTATUS_FIXED = 64'h0000_000a_0000_1800;

  // Architectural state; the low two bits of mepc/mtvec are hardwired to 0
  logic [63:0] mcause_q, mcause_d;
  logic [63:2] mepc_q, mepc_d;
  logic [63:2] mtvec_q, mtvec_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        conflict_d;

  // Decoded software write request
  logic        w_in_range;
  logic        r_in_range;
  logic [1:0]  w_idx;
  logic [1:0]  r_idx;
  logic        sw_req;
  logic        sw_drop;
  logic        sw_do;
  logic [63:0] mstatus_val;

  // trap_pc[1:0] is discarded when forming mepc
  logic unused_trap_pc_lo;
  assign unused_trap_pc_lo = ^trap_pc[1:0];

  // Indices at or above 4 are unmapped: reads give 0, writes vanish silently
  assign w_in_range = (csrf_waddr >> 2) == '0;
  assign r_in_range = (csrf_raddr >> 2) == '0;
  assign w_idx      = csrf_waddr[1:0];
  assign r_idx      = csrf_raddr[1:0];

  assign sw_req  = csrf_wen && w_in_range;
  assign sw_drop = sw_req && (trap_vld || (mret_vld && (w_idx == IDX_MSTATUS)));
  assign sw_do   = sw_req && !sw_drop;

  assign mstatus_val = MSTATUS_FIXED
                     | (64'(mie_q)  << 3)
                     | (64'(mpie_q) << 7);

  // Combinational read of current state; intentionally no write bypass
  always_comb begin
    csrf_rdata = '0;
    if (r_in_range) begin
      case (r_idx)
        IDX_MCAUSE:  csrf_rdata = mcause_q;
        IDX_MSTATUS: csrf_rdata = mstatus_val;
        IDX_MEPC:    csrf_rdata = {mepc_q, 2'b00};
        IDX_MTVEC:   csrf_rdata = {mtvec_q, 2'b00};
        default:     csrf_rdata = '0;
      endcase
    end
  end

  // Next-state: trap beats mret beats software write, with legalization
  always_comb begin
    mcause_d   = mcause_q;
    mepc_d     = mepc_q;
    mtvec_d    = mtvec_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    conflict_d = sw_drop;
    if (trap_vld) begin
      mepc_d   = trap_pc[63:2];
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else begin
      if (mret_vld) begin
        mie_d  = mpie_q;
        mpie_d = 1'b1;
      end
      // A write to mstatus during mret is already dropped, so no overlap here
      if (sw_do) begin
        case (w_idx)
          IDX_MCAUSE:  mcause_d = csrf_wdata;
          IDX_MSTATUS: begin
            mie_d  = csrf_wdata[3];
            mpie_d = csrf_wdata[7];
          end
          IDX_MEPC:    mepc_d  = csrf_wdata[63:2];
          IDX_MTVEC:   mtvec_d = csrf_wdata[63:2];
          default:     ;
        endcase
      end
    end
  end

  // State register with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcause_q    <= '0;
      mepc_q      <= '0;
      mtvec_q     <= '0;
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      mcause_q    <= mcause_d;
      mepc_q      <= mepc_d;
      mtvec_q     <= mtvec_d;
      mie_q       <= mie_d;
      mpie_q      <= mpie_d;
      wr_conflict <= conflict_d;
    end
  end

  assign mtvec_o = {mtvec_q, 2'b00};
  assign mepc_o  = {mepc_q, 2'b00};
  assign mie_o   = mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed testbench for csr_regfile, built with a 3-bit index so the
// unmapped indices 4..7 can be exercised.
module tb_csr_regfile;

  localparam int AW = 3;
  localparam int DW = 64;

  logic          clk;
  logic          rst;
  logic [AW-1:0] csrf_raddr;
  logic [DW-1:0] csrf_rdata;
  logic [AW-1:0] csrf_waddr;
  logic [DW-1:0] csrf_wdata;
  logic          csrf_wen;
  logic          trap_vld;
  logic [63:0]   trap_pc;
  logic [63:0]   trap_cause;
  logic          mret_vld;
  logic [63:0]   mtvec_o;
  logic [63:0]   mepc_o;
  logic          mie_o;
  logic          wr_conflict;

  int checks;
  int failures;

  csr_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .csrf_raddr  (csrf_raddr),
    .csrf_rdata  (csrf_rdata),
    .csrf_waddr  (csrf_waddr),
    .csrf_wdata  (csrf_wdata),
    .csrf_wen    (csrf_wen),
    .trap_vld    (trap_vld),
    .trap_pc     (trap_pc),
    .trap_cause  (trap_cause),
    .mret_vld    (mret_vld),
    .mtvec_o     (mtvec_o),
    .mepc_o      (mepc_o),
    .mie_o       (mie_o),
    .wr_conflict (wr_conflict)
  );

  // Clock: 20 ns period
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Drivers
  task automatic idle();
    csrf_wen   = 1'b0;
    csrf_waddr = '0;
    csrf_wdata = '0;
    trap_vld   = 1'b0;
    trap_pc    = '0;
    trap_cause = '0;
    mret_vld   = 1'b0;
  endtask

  // Advance past the next rising edge; inputs are then safe to change
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw_write(input logic [AW-1:0] a, input logic [63:0] d);
    csrf_wen   = 1'b1;
    csrf_waddr = a;
    csrf_wdata = d;
  endtask

  // Check indices 0..3 against expected values (reads are combinational)
  task automatic check_all(input string tag, input logic [63:0] e0,
                           input logic [63:0] e1, input logic [63:0] e2,
                           input logic [63:0] e3);
    logic [63:0] exp_r [4];
    exp_r[0] = e0; exp_r[1] = e1; exp_r[2] = e2; exp_r[3] = e3;
    for (int i = 0; i < 4; i++) begin
      csrf_raddr = AW'(i);
      #1;
      checks++;
      if (csrf_rdata !== exp_r[i]) begin
        failures++;
        $display("FAIL %s rd[%0d] got=%h exp=%h", tag, i, csrf_rdata, exp_r[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    csrf_raddr = '0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_all("reset", 64'h0, 64'ha00001800, 64'h0, 64'h0);
    checks++;
    if (mtvec_o !== 64'h0 || mepc_o !== 64'h0 || mie_o !== 1'b0 || wr_conflict !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs mtvec=%h mepc=%h mie=%b conf=%b exp all 0",
               mtvec_o, mepc_o, mie_o, wr_conflict);
    end
  endtask

  task automatic test_mtvec_write();
    tick();
    sw_write(3'd3, 64'h8000_0103);
    csrf_raddr = 3'd3;
    #1;
    checks++;
    if (csrf_rdata !== 64'h0) begin
      failures++;
      $display("FAIL mtvec_no_bypass got=%h exp=%h", csrf_rdata, 64'h0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (csrf_rdata !== 64'h8000_0100) begin
      failures++;
      $display("FAIL mtvec_read got=%h exp=%h", csrf_rdata, 64'h8000_0100);
    end
    checks++;
    if (mtvec_o !== 64'h8000_0100) begin
      failures++;
      $display("FAIL mtvec_o got=%h exp=%h", mtvec_o, 64'h8000_0100);
    end
  endtask

  task automatic test_mstatus_trap();
    sw_write(3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    idle();
    check_all("mstatus_wr", 64'h0, 64'ha00001888, 64'h0, 64'h8000_0100);
    checks++;
    if (mie_o !== 1'b1) begin
      failures++;
      $display("FAIL mstatus_mie got=%b exp=1", mie_o);
    end
    tick();
    trap_vld   = 1'b1;
    trap_pc    = 64'h8000_0046;
    trap_cause = 64'hb;
    tick();
    idle();
    check_all("trap", 64'hb, 64'ha00001880, 64'h8000_0044, 64'h8000_0100);
    checks++;
    if (mie_o !== 1'b0 || mepc_o !== 64'h8000_0044) begin
      failures++;
      $display("FAIL trap_outs mie=%b mepc=%h exp mie=0 mepc=%h", mie_o, mepc_o, 64'h8000_0044);
    end
  endtask

  task automatic test_mret();
    tick();
    mret_vld = 1'b1;
    tick();
    idle();
    check_all("mret1", 64'hb, 64'ha00001888, 64'h8000_0044, 64'h8000_0100);
    checks++;
    if (mie_o !== 1'b1) begin
      failures++;
      $display("FAIL mret1_mie got=%b exp=1", mie_o);
    end
    mret_vld = 1'b1;
    tick();
    idle();
    #1;
    csrf_raddr = 3'd1;
    #1;
    checks++;
    if (csrf_rdata !== 64'ha00001888 || mie_o !== 1'b1) begin
      failures++;
      $display("FAIL mret2 mstatus=%h mie=%b exp=%h mie=1", csrf_rdata, mie_o, 64'ha00001888);
    end
  endtask

  task automatic test_conflict();
    // trap with a same-cycle mcause write: the write is dropped
    trap_vld   = 1'b1;
    trap_pc    = 64'h8000_0100;
    trap_cause = 64'hb;
    sw_write(3'd0, 64'h5);
    tick();
    idle();
    checks++;
    if (wr_conflict !== 1'b1) begin
      failures++;
      $display("FAIL trap_conflict got=%b exp=1", wr_conflict);
    end
    check_all("trap_wr", 64'hb, 64'ha00001880, 64'h8000_0100, 64'h8000_0100);
    tick();
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++;
      $display("FAIL conflict_pulse got=%b exp=0", wr_conflict);
    end
    // mret with a write to mepc: both land
    mret_vld = 1'b1;
    sw_write(3'd2, 64'h100);
    tick();
    idle();
    checks++;
    if (wr_conflict !== 1'b0 || mie_o !== 1'b1 || mepc_o !== 64'h100) begin
      failures++;
      $display("FAIL mret_mepc conf=%b mie=%b mepc=%h exp conf=0 mie=1 mepc=%h",
               wr_conflict, mie_o, mepc_o, 64'h100);
    end
    // mret with a write to mstatus: the write is dropped
    mret_vld = 1'b1;
    sw_write(3'd1, 64'h0);
    tick();
    idle();
    checks++;
    if (wr_conflict !== 1'b1) begin
      failures++;
      $display("FAIL mret_mstatus_conflict got=%b exp=1", wr_conflict);
    end
    check_all("mret_mstatus", 64'hb, 64'ha00001888, 64'h100, 64'h8000_0100);
  endtask

  task automatic test_back_to_back();
    // ecall sequence: trap followed by a software mcause write
    trap_vld   = 1'b1;
    trap_pc    = 64'h8000_0200;
    trap_cause = 64'h3;
    tick();
    idle();
    sw_write(3'd0, 64'hb);
    csrf_raddr = 3'd0;
    #1;
    checks++;
    if (csrf_rdata !== 64'h3 || wr_conflict !== 1'b0) begin
      failures++;
      $display("FAIL b2b_trap mcause=%h conf=%b exp mcause=3 conf=0", csrf_rdata, wr_conflict);
    end
    tick();
    idle();
    check_all("b2b_sw", 64'hb, 64'ha00001880, 64'h8000_0200, 64'h8000_0100);
  endtask

  task automatic test_out_of_range();
    sw_write(3'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    idle();
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++;
      $display("FAIL oor_conflict got=%b exp=0", wr_conflict);
    end
    for (int i = 4; i < 8; i++) begin
      csrf_raddr = AW'(i);
      #1;
      checks++;
      if (csrf_rdata !== 64'h0) begin
        failures++;
        $display("FAIL oor_read[%0d] got=%h exp=0", i, csrf_rdata);
      end
    end
    check_all("oor_keep", 64'hb, 64'ha00001880, 64'h8000_0200, 64'h8000_0100);
    tick();
    // unmapped write during a trap is not a conflict
    trap_vld   = 1'b1;
    trap_pc    = 64'h8000_0300;
    trap_cause = 64'h7;
    sw_write(3'd5, 64'h1);
    tick();
    idle();
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++;
      $display("FAIL oor_trap_conflict got=%b exp=0", wr_conflict);
    end
    check_all("oor_trap", 64'h7, 64'ha00001800, 64'h8000_0300, 64'h8000_0100);
  endtask

  task automatic test_async_reset();
    tick();
    sw_write(3'd0, 64'h1234); tick();
    sw_write(3'd1, 64'h88);   tick();
    sw_write(3'd2, 64'h2000); tick();
    sw_write(3'd3, 64'h3000); tick();
    idle();
    check_all("loaded", 64'h1234, 64'ha00001888, 64'h2000, 64'h3000);
    // assert reset between edges with a request present
    @(posedge clk);
    #3;
    sw_write(3'd0, 64'hff);
    rst = 1'b1;
    #1;
    check_all("async_rst", 64'h0, 64'ha00001800, 64'h0, 64'h0);
    checks++;
    if (mtvec_o !== 64'h0 || mepc_o !== 64'h0 || mie_o !== 1'b0 || wr_conflict !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_outs mtvec=%h mepc=%h mie=%b conf=%b exp all 0",
               mtvec_o, mepc_o, mie_o, wr_conflict);
    end
    @(posedge clk);
    #3;
    idle();
    rst = 1'b0;
    tick();
    check_all("post_rst", 64'h0, 64'ha00001800, 64'h0, 64'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mtvec_write();
    test_mstatus_trap();
    test_mret();
    test_conflict();
    test_back_to_back();
    test_out_of_range();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
